team_proj_wb_regs: RTL and testbench
====================================

// Module: team_proj_wb_regs
// PURPOSE
//  Wishbone-classic slave for the team user project inside the Caravel user_project_wrapper.
//  Holds a byte-writable scratch RAM (the FFRAM), a control register and GPIO drive registers.
//  Firmware fetched from SPI flash writes and reads back the RAM, then sets CTRL.EN.
//  The en output then enables the project core and signals that the WB path works.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  Wishbone address of register 0; upper 16 bits decode the slave select.
//  RAM_WORDS  16             number of 32-bit scratch RAM words; must be a power of 2, max 64.
//  GPIO_W     34             width of the GPIO drive bus (mprj_io[37:5] plus mprj_io[0]).
// PORTS
//  clk        in   1        system clock (wb_clk_i)
//  nrst       in   1        asynchronous active-low reset
//  wbs_cyc_i  in   1        bus cycle valid
//  wbs_stb_i  in   1        strobe
//  wbs_we_i   in   1        1 = write, 0 = read
//  wbs_sel_i  in   4        byte enables
//  wbs_adr_i  in   32       byte address
//  wbs_dat_i  in   32       write data
//  wbs_ack_o  out  1        single-cycle acknowledge
//  wbs_dat_o  out  32       read data, valid while ack=1
//  en         out  1        project enable (CTRL bit 0)
//  gpio_out   out  GPIO_W   GPIO output values
//  gpio_oeb   out  GPIO_W   GPIO output enables, active-low
// BEHAVIOUR
//  - Decode: sel = cyc & stb & (adr[31:16] == BASE_ADDR[31:16]). Offset = adr[15:0].
//  - Map: 0x000 CTRL (RW, bit0 = en, other bits read 0); 0x004 GPIO_OUT (RW);
//    0x008 GPIO_OEB (RW); 0x00C ID (RO, 32'h5445_414D); 0x100 + 4*i RAM[i] (RW).
//    An unmapped offset acks, reads 0 and ignores writes.
//  - Handshake: ack rises the cycle after sel. It is high for exactly 1 cycle, then low for at least 1 cycle.
//    Back-to-back transfers therefore take 2 cycles each. A new ack is not issued while ack=1.
//  - Writes commit on the ack cycle, per byte lane from wbs_sel_i. For CTRL, only lane 0 matters.
//    For GPIO registers, bits above GPIO_W are dropped.
//  - Reads: wbs_dat_o is registered with ack. It returns 0 when ack=0.
//  - Reset: ack=0, dat_o=0, en=0, gpio_out=0, gpio_oeb = all 1 (all inputs).
//  - A reset that asserts mid-transfer aborts the transfer: no ack and no write. Reset release is
//    synchronised internally by a 2-flop deassert chain.
//  - If cyc drops before ack, the transfer is abandoned. The next sel starts a new transfer.
//  - Writing CTRL=0 clears en on the following cycle. en never changes from RAM accesses.
// CONFIGURATION
//  RAM_CLEAR_ON_RESET_EN defined: all RAM words reset asynchronously to 0.
//  RAM_CLEAR_ON_RESET_EN undefined: RAM has no reset, so contents are X until written.
//  Control and GPIO registers reset in both cases.
// STRUCTURE
//  Package team_proj_wb_pkg holds: offset localparams (CTRL/GPIO_OUT/GPIO_OEB/ID/RAM_BASE),
//  the ID constant, and the typedef for a byte-enabled write request.
//  Sub-module team_proj_ram: RAM_WORDS x 32 array, byte-lane write, synchronous read.
//  The top module holds decode, ack generation and registers.
// TESTING
//  1. Reset held, then released -> en=0, gpio_oeb=34'h3_FFFF_FFFF, ack=0, dat_o=0.
//  2. Write RAM[0]=32'hDEAD_BEEF with sel=4'hF, read it back -> 32'hDEAD_BEEF.
//     Write sel=4'h2 data 32'h0000_5500, read -> 32'hDEAD_55EF.
//  3. Read ID at 0x3000_000C -> 32'h5445_414D. Write ID, then read -> value unchanged.
//  4. Write CTRL=1 -> en=1 on the cycle after ack. Write CTRL=0 -> en=0.
//     Any other address -> en unchanged.
//  5. Write GPIO_OEB=0 and GPIO_OUT=34'h2_AAAA_AAAA -> gpio_out matches and gpio_oeb=0.
//     Access address 0x3100_0000 -> no ack.
//  6. Drop cyc before ack -> no write. Assert nrst mid-write -> no ack and registers at reset values.

Source files
------------

// File: rtl/team_proj_wb_pkg.sv
// Register map, ID constant and the captured write-request type shared by the
// team project Wishbone slave and its scratch RAM.
package team_proj_wb_pkg;

  localparam logic [15:0] OFF_CTRL     = 16'h0000;
  localparam logic [15:0] OFF_GPIO_OUT = 16'h0004;
  localparam logic [15:0] OFF_GPIO_OEB = 16'h0008;
  localparam logic [15:0] OFF_ID       = 16'h000C;
  localparam logic [15:0] OFF_RAM_BASE = 16'h0100;

  // Decode works on 32-bit word indices; the two byte-address bits are ignored.
  localparam logic [13:0] WORD_CTRL     = OFF_CTRL[15:2];
  localparam logic [13:0] WORD_GPIO_OUT = OFF_GPIO_OUT[15:2];
  localparam logic [13:0] WORD_GPIO_OEB = OFF_GPIO_OEB[15:2];
  localparam logic [13:0] WORD_ID       = OFF_ID[15:2];
  localparam logic [13:0] WORD_RAM_BASE = OFF_RAM_BASE[15:2];

  localparam logic [31:0] ID_VALUE = 32'h5445_414D;

  typedef struct packed {
    logic [13:0] word;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
  } wr_req_t;

endpackage

// File: rtl/team_proj_ram.sv
// Scratch RAM: WORDS x 32 bits, byte-lane writes, synchronous zero-gated read.
// Build option RAM_CLEAR_ON_RESET_EN: when defined, every word resets to zero.
module team_proj_ram #(
  parameter int WORDS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_word_s;
  logic [31:0] rdata_r;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] lane_mem_r [WORDS];

`ifdef RAM_CLEAR_ON_RESET_EN
    // Lane storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int w = 0; w < WORDS; w++) begin
          lane_mem_r[w] <= 8'h00;
        end
      end else if (we && wbe[b]) begin
        lane_mem_r[waddr] <= wdata[8*b +: 8];
      end
    end
`else
    // Lane storage, no reset.
    always_ff @(posedge clk) begin
      if (we && wbe[b]) begin
        lane_mem_r[waddr] <= wdata[8*b +: 8];
      end
    end
`endif

    assign mem_word_s[8*b +: 8] = lane_mem_r[raddr];
  end

  // Read register holds zero except in the cycle after a read request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_word_s;
    end else begin
      rdata_r <= 32'h0000_0000;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/team_proj_wb_regs.sv
// Wishbone-classic slave for the team user project: CTRL/en, GPIO drive registers,
// ID and a scratch RAM. Build option RAM_CLEAR_ON_RESET_EN clears the RAM on reset.
module team_proj_wb_regs
  import team_proj_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RAM_WORDS = 16,
  parameter int          GPIO_W    = 34
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              en,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oeb
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;
  logic              ack_r;
  wr_req_t           req_r;
  logic              ctrl_r;
  logic [GPIO_W-1:0] gpio_out_r;
  logic [GPIO_W-1:0] gpio_oeb_r;
  logic [GPIO_W-1:0] gpio_wdata_s;
  logic [GPIO_W-1:0] gpio_wmask_s;
  logic [31:0]       gpio_out_rd_s;
  logic [31:0]       gpio_oeb_rd_s;
  logic [31:0]       rd_reg_s;
  logic [31:0]       rd_reg_r;
  logic [31:0]       ram_rdata_s;
  logic [13:0]       word_s;
  logic              sel_s;
  logic              start_s;
  logic              commit_s;
  logic              ram_re_s;
  logic              ram_we_s;
  logic              unused_s;

  function automatic logic is_ram(input logic [13:0] word);
    return (word >= WORD_RAM_BASE) && (word < (WORD_RAM_BASE + 14'(RAM_WORDS)));
  endfunction

  // External reset asserts immediately; its release is re-timed through two flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_r[1];

  assign sel_s    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign word_s   = wbs_adr_i[15:2];
  assign unused_s = ^wbs_adr_i[1:0];
  // A request starts only while ack is low; the write lands at the end of the
  // ack cycle and only if the master still holds the cycle there.
  assign start_s  = sel_s & ~ack_r;
  assign commit_s = ack_r & sel_s & req_r.we;
  assign ram_re_s = start_s & ~wbs_we_i & is_ram(word_s);
  assign ram_we_s = commit_s & is_ram(req_r.word);

  // GPIO wider than the bus: bit i takes data bit i mod 32 in that bit's lane.
  for (genvar g = 0; g < GPIO_W; g++) begin : g_gpio_wr
    assign gpio_wdata_s[g] = req_r.data[g % 32];
    assign gpio_wmask_s[g] = req_r.be[(g % 32) / 8];
  end

  for (genvar g = 0; g < 32; g++) begin : g_gpio_rd
    if (g < GPIO_W) begin : g_bit
      assign gpio_out_rd_s[g] = gpio_out_r[g];
      assign gpio_oeb_rd_s[g] = gpio_oeb_r[g];
    end else begin : g_pad
      assign gpio_out_rd_s[g] = 1'b0;
      assign gpio_oeb_rd_s[g] = 1'b0;
    end
  end

  // Register-side read mux; RAM words and unmapped offsets read as zero here.
  always_comb begin
    rd_reg_s = 32'h0000_0000;
    case (word_s)
      WORD_CTRL:     rd_reg_s = {31'h0000_0000, ctrl_r};
      WORD_GPIO_OUT: rd_reg_s = gpio_out_rd_s;
      WORD_GPIO_OEB: rd_reg_s = gpio_oeb_rd_s;
      WORD_ID:       rd_reg_s = ID_VALUE;
      default:       rd_reg_s = 32'h0000_0000;
    endcase
  end

  // Handshake: single-cycle ack, captured request and zero-gated read data.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ack_r    <= 1'b0;
      req_r    <= '0;
      rd_reg_r <= 32'h0000_0000;
    end else begin
      ack_r <= start_s;
      if (start_s) begin
        req_r <= '{word: word_s, data: wbs_dat_i, be: wbs_sel_i, we: wbs_we_i};
      end else begin
        req_r <= req_r;
      end
      if (start_s && !wbs_we_i) begin
        rd_reg_r <= rd_reg_s;
      end else begin
        rd_reg_r <= 32'h0000_0000;
      end
    end
  end

  // Control and GPIO registers, written on commit.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ctrl_r     <= 1'b0;
      gpio_out_r <= '0;
      gpio_oeb_r <= '1;
    end else begin
      if (commit_s && (req_r.word == WORD_CTRL) && req_r.be[0]) begin
        ctrl_r <= req_r.data[0];
      end
      if (commit_s && (req_r.word == WORD_GPIO_OUT)) begin
        gpio_out_r <= (gpio_out_r & ~gpio_wmask_s) | (gpio_wdata_s & gpio_wmask_s);
      end
      if (commit_s && (req_r.word == WORD_GPIO_OEB)) begin
        gpio_oeb_r <= (gpio_oeb_r & ~gpio_wmask_s) | (gpio_wdata_s & gpio_wmask_s);
      end
    end
  end

  team_proj_ram #(
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n_s),
    .we    (ram_we_s),
    .waddr (req_r.word[RAM_AW-1:0]),
    .wdata (req_r.data),
    .wbe   (req_r.be),
    .re    (ram_re_s),
    .raddr (word_s[RAM_AW-1:0]),
    .rdata (ram_rdata_s)
  );

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = rd_reg_r | ram_rdata_s;
  assign en        = ctrl_r;
  assign gpio_out  = gpio_out_r;
  assign gpio_oeb  = gpio_oeb_r;

endmodule

// File: tb/tb_team_proj_wb_regs.sv
// Self-checking bench for team_proj_wb_regs: directed vector table, hand-written
// handshake/abort/reset sequences and random traffic against a register-map model.
module tb_team_proj_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic        en;
  logic [33:0] gpio_out, gpio_oeb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  team_proj_wb_regs dut (
    .clk       (clk),
    .nrst      (nrst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .en        (en),
    .gpio_out  (gpio_out),
    .gpio_oeb  (gpio_oeb)
  );

  // Reference model of the register map.
  logic [31:0] m_ram [16];
  logic        m_ctrl;
  logic [33:0] m_gout, m_goeb;

  function automatic logic [33:0] gpio_merge(input logic [33:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [33:0] r;
    r = old;
    for (int i = 0; i < 34; i++) begin
      if (s[(i % 32) / 8]) r[i] = d[i % 32];
    end
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int off;
    if (a[31:16] != BASE[31:16]) return;
    off = int'(a[15:0]) & 32'hFFFC;
    if (off == 0) begin
      if (s[0]) m_ctrl = d[0];
    end else if (off == 4) begin
      m_gout = gpio_merge(m_gout, d, s);
    end else if (off == 8) begin
      m_goeb = gpio_merge(m_goeb, d, s);
    end else if (off >= 256 && off < 256 + 64) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) m_ram[(off - 256) / 4][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int off;
    off = int'(a[15:0]) & 32'hFFFC;
    if (off == 0)  return {31'd0, m_ctrl};
    if (off == 4)  return m_gout[31:0];
    if (off == 8)  return m_goeb[31:0];
    if (off == 12) return 32'h5445_414D;
    if (off >= 256 && off < 256 + 64) return m_ram[(off - 256) / 4];
    return 32'h0000_0000;
  endfunction

  task automatic model_reset();
    m_ctrl = 1'b0;
    m_gout = 34'h0;
    m_goeb = 34'h3_FFFF_FFFF;
`ifdef RAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 16; i++) m_ram[i] = 32'h0;
`endif
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_w = 32'h0;
  endtask

  task automatic bus_drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
  endtask

  // One Wishbone transfer; holds the bus through the edge that ends the ack cycle.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic acked, output logic [31:0] rd,
                      output int lat, output logic ack_after, output logic [31:0] dat_after);
    acked = 1'b0; rd = 32'h0; lat = 0;
    @(negedge clk);
    bus_drive(w, a, d, s);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1; rd = dat_r; lat = c;
        break;
      end
    end
    if (acked) begin
      @(posedge clk); #1;
    end
    ack_after = ack;
    dat_after = dat_r;
    bus_idle();
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[17];

  initial begin : main
    logic acked, ack_after;
    logic [31:0] rd, dat_after, exp_rd, a, d;
    logic [3:0] s;
    logic w, exp_ack;
    int lat;

    vecs[0]  = '{1'b0, 32'h3000_0008, 32'h0,          4'hF, 1'b1, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 32'h3000_0000, 32'h0,          4'hF, 1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'h3000_0100, 32'hDEAD_BEEF,  4'hF, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h3000_0100, 32'h0,          4'hF, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h3000_0100, 32'h0000_5500,  4'h2, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h3000_0100, 32'h0,          4'hF, 1'b1, 32'hDEAD_55EF};
    vecs[6]  = '{1'b0, 32'h3000_000C, 32'h0,          4'hF, 1'b1, 32'h5445_414D};
    vecs[7]  = '{1'b1, 32'h3000_000C, 32'h1234_5678,  4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h3000_000C, 32'h0,          4'hF, 1'b1, 32'h5445_414D};
    vecs[9]  = '{1'b1, 32'h3000_0008, 32'h0000_0000,  4'hF, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h3000_0004, 32'hAAAA_AAAA,  4'hF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h3000_0004, 32'h0,          4'hF, 1'b1, 32'hAAAA_AAAA};
    vecs[12] = '{1'b0, 32'h3000_0008, 32'h0,          4'hF, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b1, 32'h3000_0200, 32'hFFFF_FFFF,  4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h3000_0200, 32'h0,          4'hF, 1'b1, 32'h0000_0000};
    vecs[15] = '{1'b1, 32'h3100_0000, 32'h1111_1111,  4'hF, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h3100_0000, 32'h0,          4'hF, 1'b0, 32'h0};

    // Reset state while held and after release.
    bus_idle();
    nrst = 1'b1;
    #1 nrst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_en", en, 64'd0);
    chk("rst_hold_oeb", gpio_oeb, 64'h3_FFFF_FFFF);
    chk("rst_hold_out", gpio_out, 64'h0);
    chk("rst_hold_ack", ack, 64'd0);
    @(negedge clk) nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rel_en", en, 64'd0);
    chk("rst_rel_oeb", gpio_oeb, 64'h3_FFFF_FFFF);
    chk("rst_rel_ack", ack, 64'd0);
    chk("rst_rel_dat", dat_r, 64'd0);

    // Directed vector table.
    foreach (vecs[i]) begin
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, acked, rd, lat, ack_after, dat_after);
      chk($sformatf("vec%0d_ack", i), acked, vecs[i].exp_ack);
      if (vecs[i].exp_ack) begin
        chk($sformatf("vec%0d_latency", i), lat, 64'd1);
        chk($sformatf("vec%0d_ack_drop", i), ack_after, 64'd0);
        chk($sformatf("vec%0d_dat_idle", i), dat_after, 64'd0);
        if (vecs[i].w) model_write(vecs[i].a, vecs[i].d, vecs[i].s);
      end
      if (!vecs[i].w) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
    end
    chk("gpio_out_pattern", gpio_out, 64'h2_AAAA_AAAA);
    chk("gpio_oeb_zero", gpio_oeb, 64'h0);

    // CTRL write: en rises after the ack cycle, not during it.
    @(negedge clk);
    bus_drive(1'b1, BASE, 32'h0000_0001, 4'hF);
    @(posedge clk); #1;
    chk("ctrl_ack", ack, 64'd1);
    chk("en_during_ack", en, 64'd0);
    @(posedge clk); #1;
    chk("en_after_ack", en, 64'd1);
    chk("ctrl_ack_low", ack, 64'd0);
    bus_idle();
    model_write(BASE, 32'h1, 4'hF);
    xfer(1'b1, BASE + 32'h108, 32'h0, 4'hF, acked, rd, lat, ack_after, dat_after);
    model_write(BASE + 32'h108, 32'h0, 4'hF);
    chk("en_ram_write", en, 64'd1);
    xfer(1'b1, BASE, 32'h0, 4'hE, acked, rd, lat, ack_after, dat_after);
    chk("en_lane0_off", en, 64'd1);
    xfer(1'b1, BASE, 32'h0, 4'h1, acked, rd, lat, ack_after, dat_after);
    model_write(BASE, 32'h0, 4'h1);
    chk("en_cleared", en, 64'd0);

    // Abandoned transfers leave the RAM untouched.
    xfer(1'b1, BASE + 32'h104, 32'h1234_5678, 4'hF, acked, rd, lat, ack_after, dat_after);
    model_write(BASE + 32'h104, 32'h1234_5678, 4'hF);
    @(negedge clk);
    bus_drive(1'b1, BASE + 32'h104, 32'hFFFF_FFFF, 4'hF);
    #2 bus_idle();
    repeat (2) @(posedge clk);
    #1 chk("drop_early_no_ack", ack, 64'd0);
    @(negedge clk);
    bus_drive(1'b1, BASE + 32'h104, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    bus_idle();
    repeat (2) @(posedge clk);
    xfer(1'b0, BASE + 32'h104, 32'h0, 4'hF, acked, rd, lat, ack_after, dat_after);
    chk("drop_no_write", rd, 64'h1234_5678);
    chk("drop_next_latency", lat, 64'd1);

    // Fill the RAM, then random traffic against the model.
    for (int i = 0; i < 16; i++) begin
      d = $urandom();
      xfer(1'b1, BASE + 32'h100 + 32'(4 * i), d, 4'hF, acked, rd, lat, ack_after, dat_after);
      model_write(BASE + 32'h100 + 32'(4 * i), d, 4'hF);
    end
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: a = BASE;
        1: a = BASE + 32'h4;
        2: a = BASE + 32'h8;
        3: a = BASE + 32'hC;
        7: a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 59));
        8: a = BASE + 32'h140 + 32'(4 * $urandom_range(0, 15));
        9: a = 32'h3100_0000 + 32'(4 * $urandom_range(0, 3));
        default: a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom();
      s = 4'($urandom_range(0, 15));
      exp_ack = (a[31:16] == BASE[31:16]);
      exp_rd = model_read(a);
      xfer(w, a, d, s, acked, rd, lat, ack_after, dat_after);
      chk($sformatf("rnd%0d_ack", n), acked, exp_ack);
      if (exp_ack && !w) chk($sformatf("rnd%0d_rd a=%h", n, a), rd, exp_rd);
      if (exp_ack && w) model_write(a, d, s);
      chk($sformatf("rnd%0d_en", n), en, m_ctrl);
      chk($sformatf("rnd%0d_gout", n), gpio_out, m_gout);
      chk($sformatf("rnd%0d_goeb", n), gpio_oeb, m_goeb);
    end

    // Reset asserted during the ack cycle of a write aborts it.
    xfer(1'b1, BASE, 32'h1, 4'hF, acked, rd, lat, ack_after, dat_after);
    xfer(1'b1, BASE + 32'h4, 32'h5555_5555, 4'hF, acked, rd, lat, ack_after, dat_after);
    @(negedge clk);
    bus_drive(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #2;
    nrst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_ack", ack, 64'd0);
    chk("rst_mid_en", en, 64'd0);
    chk("rst_mid_out", gpio_out, 64'h0);
    chk("rst_mid_oeb", gpio_oeb, 64'h3_FFFF_FFFF);
    chk("rst_mid_dat", dat_r, 64'd0);
    @(negedge clk) bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rst_after_out", gpio_out, 64'h0);
    xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, acked, rd, lat, ack_after, dat_after);
    chk("rst_after_rd_gout", rd, 64'h0);
    xfer(1'b0, BASE + 32'h104, 32'h0, 4'hF, acked, rd, lat, ack_after, dat_after);
    chk("rst_after_ram", rd, model_read(BASE + 32'h104));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

endmodule
